// File: rtl/synth_pkg.sv
// Shared note tables, request payload and period lookup for the tone generator.
package synth_pkg;

  localparam int unsigned TBL_W      = 16;
  localparam int unsigned NOTE_OCT_W = 4;
  localparam int unsigned N_NOTES    = 13;

  localparam logic [3:0] NOTE_REST_MIN = 4'd13;

  // Full-period counts for C low .. C high at 10 MHz and 12 MHz.
  localparam logic [TBL_W-1:0] TBL_10M [N_NOTES] = '{
    16'd38223, 16'd36077, 16'd34052, 16'd32141, 16'd30337, 16'd28635, 16'd27027,
    16'd25511, 16'd24079, 16'd22727, 16'd21452, 16'd20248, 16'd19111
  };

  localparam logic [TBL_W-1:0] TBL_12M [N_NOTES] = '{
    16'd45868, 16'd43292, 16'd40862, 16'd38569, 16'd36404, 16'd34362, 16'd32432,
    16'd30613, 16'd28895, 16'd27272, 16'd25742, 16'd24298, 16'd22933
  };

  typedef struct packed {
    logic [3:0]            idx;
    logic [NOTE_OCT_W-1:0] octave;
    logic                  sel12;
  } note_req_t;

  // Rest indices map to 0; a note never yields a period below 1 so the counter always wraps.
  function automatic logic [TBL_W-1:0] period_of(input logic [3:0]            idx,
                                                 input logic [NOTE_OCT_W-1:0] oct,
                                                 input logic                  sel12);
    logic [TBL_W-1:0] base;
    logic [TBL_W-1:0] shifted;
    base    = '0;
    shifted = '0;
    if (idx < NOTE_REST_MIN) begin
      base    = sel12 ? TBL_12M[idx] : TBL_10M[idx];
      shifted = base >> oct;
      if (shifted == '0) begin
        shifted = TBL_W'(1);
      end
    end
    return shifted;
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One square-wave voice: pending note slot, period counter and wave/ack flops.
module tone_channel
  import synth_pkg::*;
#(
  parameter int unsigned OCT_W = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             is_fpga_i,
  input  logic             note_valid_i,
  input  logic [3:0]       note_idx_i,
  input  logic [OCT_W-1:0] octave_i,
  output logic             note_ack_o,
  output logic             wave_o,
  output logic             active_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0] period_q,   period_d;
  note_req_t        pend_q,     pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             ack_q,      ack_d;
  logic             wave_q,     wave_d;

  logic             capture_c;
  logic             at_wrap_c;
  logic             apply_c;
  logic [CNT_W-1:0] new_period_c;

  assign capture_c    = en_i & note_valid_i;
  assign at_wrap_c    = (cnt_q == period_q - CNT_W'(1));
  // Note changes only land on a period boundary so no half-period is ever truncated.
  assign apply_c      = pend_vld_q & ((state_q == ST_IDLE) | at_wrap_c);
  assign new_period_c = CNT_W'(period_of(pend_q.idx, pend_q.octave, pend_q.sel12));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ack_d      = capture_c;

    if (state_q == ST_PLAY) begin
      cnt_d = at_wrap_c ? '0 : cnt_q + CNT_W'(1);
    end

    if (apply_c) begin
      pend_vld_d = 1'b0;
      cnt_d      = '0;
      if (pend_q.idx >= NOTE_REST_MIN) begin
        state_d  = ST_IDLE;
        period_d = '0;
      end else begin
        state_d  = ST_PLAY;
        period_d = new_period_c;
      end
    end

    // A capture on the apply edge refills the slot after the old value is consumed.
    if (capture_c) begin
      pend_d     = note_req_t'{idx: note_idx_i, octave: NOTE_OCT_W'(octave_i), sel12: is_fpga_i};
      pend_vld_d = 1'b1;
    end

    if (!en_i) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      period_d   = '0;
      pend_d     = '0;
      pend_vld_d = 1'b0;
    end

    wave_d = (state_d == ST_PLAY) && (cnt_d < (period_d >> 1));
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      wave_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ack_q      <= ack_d;
      wave_q     <= wave_d;
    end
  end

  assign note_ack_o = ack_q;
  assign wave_o     = wave_q;
  assign active_o   = (state_q == ST_PLAY);

endmodule

// File: rtl/poly_tone_generator.sv
// Multi-channel square-wave note generator with a registered voice-count mix output.
module poly_tone_generator
  import synth_pkg::*;
#(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned OCT_W = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        is_FPGA,
  input  logic                        en,
  input  logic [N_CH-1:0]             note_valid,
  input  logic [4*N_CH-1:0]           note_idx,
  input  logic [OCT_W*N_CH-1:0]       octave,
  output logic [N_CH-1:0]             note_ack,
  output logic [N_CH-1:0]             wave,
  output logic [N_CH-1:0]             active,
  output logic [$clog2(N_CH+1)-1:0]   mix
);

  localparam int unsigned MIX_W = $clog2(N_CH + 1);

  logic [MIX_W-1:0] pop_c;
  logic [MIX_W-1:0] mix_q, mix_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tone_channel #(
      .OCT_W (OCT_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst_i        (rst),
      .en_i         (en),
      .is_fpga_i    (is_FPGA),
      .note_valid_i (note_valid[i]),
      .note_idx_i   (note_idx[4*i +: 4]),
      .octave_i     (octave[OCT_W*i +: OCT_W]),
      .note_ack_o   (note_ack[i]),
      .wave_o       (wave[i]),
      .active_o     (active[i])
    );
  end

  always_comb begin
    pop_c = '0;
    for (int i = 0; i < N_CH; i++) begin
      pop_c = pop_c + MIX_W'(wave[i]);
    end
  end

  // Cleared with en so every output is quiet one cycle after en falls.
  always_comb begin
    mix_d = en ? pop_c : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mix_q <= '0;
    end else begin
      mix_q <= mix_d;
    end
  end

  assign mix = mix_q;

endmodule

// File: tb/tb_poly_tone_generator.sv
// Directed bench for poly_tone_generator: note periods, boundary changes, rests, enable, mix, reset.
module tb_poly_tone_generator;

  localparam int unsigned N_CH  = 2;
  localparam int unsigned OCT_W = 2;
  localparam int unsigned CNT_W = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     is_FPGA;
  logic                     en;
  logic [N_CH-1:0]          note_valid;
  logic [4*N_CH-1:0]        note_idx;
  logic [OCT_W*N_CH-1:0]    octave;
  logic [N_CH-1:0]          note_ack;
  logic [N_CH-1:0]          wave;
  logic [N_CH-1:0]          active;
  logic [1:0]               mix;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  poly_tone_generator #(
    .N_CH  (N_CH),
    .OCT_W (OCT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .is_FPGA    (is_FPGA),
    .en         (en),
    .note_valid (note_valid),
    .note_idx   (note_idx),
    .octave     (octave),
    .note_ack   (note_ack),
    .wave       (wave),
    .active     (active),
    .mix        (mix)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input int ch, input int idx, input int oct, input logic sel);
    note_idx[4*ch +: 4]         = 4'(idx);
    octave[OCT_W*ch +: OCT_W]   = OCT_W'(oct);
    is_FPGA                     = sel;
    note_valid[ch]              = 1'b1;
  endtask

  task automatic run_len(input int ch, input logic lvl, output int n);
    n = 0;
    while (wave[ch] === lvl && n < 50000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic go_idle(input string tag);
    en = 1'b0;
    step();
    chk({tag, "_idle"}, 32'(active), 32'(0));
    en = 1'b1;
  endtask

  function automatic int pc(input logic [N_CH-1:0] v);
    int c = 0;
    for (int i = 0; i < N_CH; i++) c += int'(v[i]);
    return c;
  endfunction

  // Load one note on ch0 from idle and measure its first high run, low run and restart.
  task automatic play_check(input string tag, input int idx, input int oct, input logic sel,
                            input int exp_hi, input int exp_lo);
    int n;
    go_idle(tag);
    load(0, idx, oct, sel);
    step();
    note_valid = '0;
    chk({tag, "_ack"}, 32'(note_ack[0]), 32'(1));
    chk({tag, "_act_pre"}, 32'(active[0]), 32'(0));
    step();
    chk({tag, "_ack_off"}, 32'(note_ack[0]), 32'(0));
    chk({tag, "_act"}, 32'(active[0]), 32'(1));
    run_len(0, 1'b1, n);
    chk({tag, "_high"}, 32'(n), 32'(exp_hi));
    run_len(0, 1'b0, n);
    chk({tag, "_low"}, 32'(n), 32'(exp_lo));
    chk({tag, "_rehigh"}, 32'(wave[0]), 32'(1));
  endtask

  initial begin
    int n;
    int errs;
    int quiet;
    logic [N_CH-1:0] prev;
    logic [3:0] seen;

    rst        = 1'b1;
    en         = 1'b0;
    is_FPGA    = 1'b0;
    note_valid = '0;
    note_idx   = '0;
    octave     = '0;
    repeat (3) step();
    chk("rst_ack",    32'(note_ack), 32'(0));
    chk("rst_wave",   32'(wave),     32'(0));
    chk("rst_active", 32'(active),   32'(0));
    chk("rst_mix",    32'(mix),      32'(0));
    rst = 1'b0;
    en  = 1'b1;
    step();

    // Note 9: 22727 / 11363 / 27272 full periods.
    play_check("n9_o0",   9, 0, 1'b0, 11363, 11364);
    play_check("n9_o1",   9, 1, 1'b0, 5681,  5682);
    play_check("n9_fpga", 9, 0, 1'b1, 13636, 13636);

    // Boundary change: note 0 oct 2 (9555) switched at cnt 1000 to note 12 oct 2 (4777).
    go_idle("mid");
    load(0, 0, 2, 1'b0);
    step();
    note_valid = '0;
    step();
    repeat (1000) step();
    load(0, 12, 2, 1'b0);
    step();
    note_valid = '0;
    chk("mid_ack", 32'(note_ack[0]), 32'(1));
    run_len(0, 1'b1, n);
    chk("mid_old_high", 32'(n), 32'(3776));
    run_len(0, 1'b0, n);
    chk("mid_old_low", 32'(n), 32'(4778));
    run_len(0, 1'b1, n);
    chk("mid_new_high", 32'(n), 32'(2388));
    run_len(0, 1'b0, n);
    chk("mid_new_low", 32'(n), 32'(2389));

    // Rest during play: note 12 oct 3 (2388) finishes its period, then idles.
    go_idle("rest");
    load(0, 12, 3, 1'b0);
    step();
    note_valid = '0;
    step();
    n = 0;
    while (active[0] === 1'b1 && n < 10000) begin
      if (n == 100) load(0, 14, 0, 1'b0);
      if (n == 101) begin
        note_valid = '0;
        chk("rest_ack", 32'(note_ack[0]), 32'(1));
      end
      n++;
      step();
    end
    chk("rest_active_len", 32'(n), 32'(2388));
    chk("rest_wave", 32'(wave[0]), 32'(0));
    load(0, 13, 0, 1'b0);
    step();
    note_valid = '0;
    chk("rest_idle_ack", 32'(note_ack[0]), 32'(1));
    repeat (5) step();
    chk("rest_idle_stay", 32'(active[0]), 32'(0));

    // Two voices: ch0 note 0 oct 3 (4777), ch1 note 12 oct 3 (2388).
    go_idle("mix");
    load(0, 0, 3, 1'b0);
    load(1, 12, 3, 1'b0);
    step();
    note_valid = '0;
    chk("mix_ack", 32'(note_ack), 32'(3));
    step();
    prev = wave;
    errs = 0;
    seen = '0;
    repeat (4000) begin
      step();
      if (mix !== 2'(pc(prev)) || mix > 2'd2) errs++;
      seen[mix] = 1'b1;
      prev = wave;
    end
    chk("mix_track", 32'(errs), 32'(0));
    chk("mix_values", 32'(seen), 32'(4'b0111));
    chk("mix_both_active", 32'(active), 32'(3));

    // Enable drop mid-tone; valid while disabled is ignored.
    en = 1'b0;
    step();
    chk("en_wave",   32'(wave),   32'(0));
    chk("en_active", 32'(active), 32'(0));
    chk("en_mix",    32'(mix),    32'(0));
    load(0, 5, 0, 1'b0);
    step();
    note_valid = '0;
    chk("en_no_ack", 32'(note_ack), 32'(0));
    step();
    en = 1'b1;
    quiet = 0;
    repeat (20) begin
      step();
      if (wave !== '0 || active !== '0 || mix !== '0 || note_ack !== '0) quiet++;
    end
    chk("en_stay_quiet", 32'(quiet), 32'(0));

    // Reset during play.
    load(0, 0, 0, 1'b0);
    load(1, 12, 0, 1'b0);
    step();
    note_valid = '0;
    repeat (50) step();
    chk("rst_pre_active", 32'(active), 32'(3));
    rst = 1'b1;
    step();
    chk("rst_run_wave",   32'(wave),     32'(0));
    chk("rst_run_active", 32'(active),   32'(0));
    chk("rst_run_mix",    32'(mix),      32'(0));
    chk("rst_run_ack",    32'(note_ack), 32'(0));
    rst = 1'b0;
    repeat (3) step();
    chk("rst_post_idle", 32'(active), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
